// File: rtl/saradc_sar_ctrl.sv
// SAR ADC successive-approximation controller.
// Sequences sample-and-hold, resolves NBITS bits MSB-first from the comparator
// decision, then presents the result on DATA with a one-cycle VALID strobe.
// Every output comes straight from a register, so no input reaches an output
// combinationally.
module saradc_sar_ctrl #(
    parameter int unsigned NBITS   = 8,
    parameter int unsigned NSAMPLE = 2
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             START,
    input  logic             CONT,
    input  logic             CMPO,
    output logic             SAMPLE,
    output logic [NBITS-1:0] RESULTP,
    output logic [NBITS-1:0] RESULTN,
    output logic             VALID,
    output logic [NBITS-1:0] DATA,
    output logic             BUSY
);

    localparam int unsigned KW = (NBITS > 1) ? $clog2(NBITS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SAMP,
        S_CONV,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [3:0]       r_scnt;
    logic [KW-1:0]    r_k;
    logic             r_sample;
    logic             r_valid;
    logic             r_busy;
    logic [NBITS-1:0] r_resp;
    logic [NBITS-1:0] r_resn;
    logic [NBITS-1:0] r_data;

    logic             w_go;
    logic [NBITS-1:0] w_resp_next;
    logic [NBITS-1:0] w_resn_next;

    assign w_go = START | CONT;

    // Result vectors with the current trial bit k resolved from the comparator.
    always_comb begin
        w_resp_next      = r_resp;
        w_resn_next      = r_resn;
        w_resp_next[r_k] = CMPO;
        w_resn_next[r_k] = ~CMPO;
    end

    // Conversion FSM with registered outputs.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            r_state  <= S_IDLE;
            r_scnt   <= '0;
            r_k      <= '0;
            r_sample <= 1'b0;
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
            r_resp   <= '0;
            r_resn   <= '0;
            r_data   <= '0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_go) begin
                        r_state  <= S_SAMP;
                        r_sample <= 1'b1;
                        r_busy   <= 1'b1;
                        r_scnt   <= 4'(NSAMPLE - 1);
                        r_resp   <= '0;
                        r_resn   <= '0;
                    end
                end
                S_SAMP: begin
                    // START is ignored here: no queueing while busy.
                    if (r_scnt == '0) begin
                        r_state  <= S_CONV;
                        r_sample <= 1'b0;
                        r_k      <= KW'(NBITS - 1);
                    end else begin
                        r_scnt <= r_scnt - 4'd1;
                    end
                end
                S_CONV: begin
                    r_resp <= w_resp_next;
                    r_resn <= w_resn_next;
                    if (r_k == '0) begin
                        // DATA takes the completed word including the bit decided on this edge.
                        r_state <= S_DONE;
                        r_valid <= 1'b1;
                        r_data  <= w_resp_next;
                    end else begin
                        r_k <= r_k - 1'b1;
                    end
                end
                S_DONE: begin
                    if (w_go) begin
                        r_state  <= S_SAMP;
                        r_sample <= 1'b1;
                        r_busy   <= 1'b1;
                        r_scnt   <= 4'(NSAMPLE - 1);
                        r_resp   <= '0;
                        r_resn   <= '0;
                    end else begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_sample <= 1'b0;
                    r_busy   <= 1'b0;
                end
            endcase
        end
    end

    assign SAMPLE  = r_sample;
    assign VALID   = r_valid;
    assign BUSY    = r_busy;
    assign RESULTP = r_resp;
    assign RESULTN = r_resn;
    assign DATA    = r_data;

endmodule

// File: tb/tb_saradc_sar_ctrl.sv
// Directed bench for saradc_sar_ctrl: default 8-bit instance plus a 2-bit,
// single-sample-cycle instance for the narrow boundary.
module tb_saradc_sar_ctrl;

    logic       clk = 1'b0;
    logic       rstn;
    logic       start, cont, cmpo;
    logic       sample, valid, busy;
    logic [7:0] resp, resn, data;

    logic       start2, cont2, cmpo2;
    logic       sample2, valid2, busy2;
    logic [1:0] resp2, resn2, data2;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Monitor state (main DUT)
    int   n_valid   = 0;
    int   n_srise   = 0;
    int   n_overlap = 0;
    logic prev_samp = 1'b0;

    saradc_sar_ctrl #(.NBITS(8), .NSAMPLE(2)) u_dut (
        .CLK(clk), .RSTN(rstn), .START(start), .CONT(cont), .CMPO(cmpo),
        .SAMPLE(sample), .RESULTP(resp), .RESULTN(resn), .VALID(valid),
        .DATA(data), .BUSY(busy)
    );

    saradc_sar_ctrl #(.NBITS(2), .NSAMPLE(1)) u_dut2 (
        .CLK(clk), .RSTN(rstn), .START(start2), .CONT(cont2), .CMPO(cmpo2),
        .SAMPLE(sample2), .RESULTP(resp2), .RESULTN(resn2), .VALID(valid2),
        .DATA(data2), .BUSY(busy2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    // Count VALID pulses, SAMPLE rises and SAMPLE/VALID overlap on the main DUT.
    always @(negedge clk) begin
        if (valid) n_valid = n_valid + 1;
        if (sample && !prev_samp) n_srise = n_srise + 1;
        if (sample && valid) n_overlap = n_overlap + 1;
        prev_samp = sample;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_mon();
        n_valid = 0;
        n_srise = 0;
    endtask

    // Single 8-bit conversion; cycle t+1 is the one right after the START edge.
    task automatic run_conv8(input string tag, input logic [7:0] pat);
        logic [7:0] npat;
        int         early;
        npat  = ~pat;
        early = 0;
        start = 1'b1;
        tick();                                     // cycle t+1
        start = 1'b0;
        check({tag, "_samp1"}, 32'(sample), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd1);
        check({tag, "_clrp"}, 32'(resp), 32'd0);
        check({tag, "_clrn"}, 32'(resn), 32'd0);
        tick();                                     // cycle t+2
        check({tag, "_samp2"}, 32'(sample), 32'd1);
        tick();                                     // cycle t+3, CONV
        check({tag, "_samp3"}, 32'(sample), 32'd0);
        for (int i = 7; i >= 0; i--) begin
            if (valid) early = early + 1;
            cmpo = pat[i];
            tick();
        end                                         // cycle t+11
        check({tag, "_early_valid"}, 32'(early), 32'd0);
        check({tag, "_valid"}, 32'(valid), 32'd1);
        check({tag, "_data"}, 32'(data), 32'(pat));
        check({tag, "_resn"}, 32'(resn), 32'(npat));
        tick();                                     // back to IDLE
        check({tag, "_valid_off"}, 32'(valid), 32'd0);
        check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int vc[4];
        int rc[4];
        int nv;
        int nr;
        logic ps;

        rstn = 1'b0; start = 1'b0; cont = 1'b0; cmpo = 1'b0;
        start2 = 1'b0; cont2 = 1'b0; cmpo2 = 1'b0;

        // Reset state
        tick(); tick();
        check("rst_sample", 32'(sample), 32'd0);
        check("rst_valid",  32'(valid),  32'd0);
        check("rst_busy",   32'(busy),   32'd0);
        check("rst_data",   32'(data),   32'd0);
        rstn = 1'b1;
        tick();
        check("idle_busy", 32'(busy), 32'd0);

        // Single conversion, pattern 1,0,1,1,0,0,1,1
        clr_mon();
        run_conv8("single", 8'hB3);
        check("single_nvalid", 32'(n_valid), 32'd1);
        check("single_nsrise", 32'(n_srise), 32'd1);

        // Bit progression with CMPO held high
        cmpo  = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();                             // into CONV
        tick(); tick(); tick();                     // three CONV edges
        check("prog_resp3", 32'(resp), 32'hE0);
        check("prog_resn3", 32'(resn), 32'h00);
        check("prog_hold_data", 32'(data), 32'hB3);
        for (int i = 0; i < 5; i++) tick();
        check("prog_valid", 32'(valid), 32'd1);
        check("prog_data", 32'(data), 32'hFF);
        tick();

        // START re-pulsed in CONV cycle 4
        clr_mon();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();                             // CONV cycle 1
        for (int i = 7; i >= 0; i--) begin
            cmpo  = 8'h5A >> i;
            start = (i == 4);
            tick();
            start = 1'b0;
            if (i == 4) check("busy_data_held", 32'(data), 32'hFF);
        end
        check("busy_valid", 32'(valid), 32'd1);
        check("busy_data", 32'(data), 32'h5A);
        for (int i = 0; i < 4; i++) tick();
        check("busy_nvalid", 32'(n_valid), 32'd1);
        check("busy_nsrise", 32'(n_srise), 32'd1);
        check("busy_idle", 32'(busy), 32'd0);

        // Reset during CONV cycle 5
        clr_mon();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();                             // CONV cycle 1
        for (int i = 7; i >= 4; i--) begin
            cmpo = 8'h3C >> i;
            tick();
        end                                         // CONV cycle 5
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        check("mrst_sample", 32'(sample), 32'd0);
        check("mrst_valid",  32'(valid),  32'd0);
        check("mrst_busy",   32'(busy),   32'd0);
        check("mrst_resp",   32'(resp),   32'd0);
        check("mrst_resn",   32'(resn),   32'd0);
        check("mrst_data",   32'(data),   32'd0);
        for (int i = 0; i < 3; i++) tick();
        check("mrst_nvalid", 32'(n_valid), 32'd0);
        check("mrst_idle",   32'(busy),    32'd0);
        run_conv8("fresh", 8'hC6);

        // Continuous mode, three conversions with CMPO low
        cmpo = 1'b0;
        cont = 1'b1;
        nv = 0; nr = 0; ps = sample;
        for (int i = 0; i < 60 && nv < 3; i++) begin
            tick();
            if (sample && !ps && nr < 4) begin
                rc[nr] = cyc;
                nr = nr + 1;
            end
            ps = sample;
            if (valid) begin
                vc[nv] = cyc;
                nv = nv + 1;
                if (nv == 3) cont = 1'b0;
            end
        end
        check("cont_nvalid", 32'(nv), 32'd3);
        check("cont_nrise",  32'(nr), 32'd3);
        if (nv == 3 && nr == 3) begin
            check("cont_lat0",  32'(vc[0] - rc[0]), 32'd10);
            check("cont_per1",  32'(vc[1] - vc[0]), 32'd11);
            check("cont_per2",  32'(vc[2] - vc[1]), 32'd11);
            check("cont_rise1", 32'(rc[1] - vc[0]), 32'd1);
            check("cont_rise2", 32'(rc[2] - vc[1]), 32'd1);
        end
        check("cont_data", 32'(data), 32'h00);
        tick();
        check("cont_stop", 32'(busy), 32'd0);
        check("no_overlap", 32'(n_overlap), 32'd0);

        // Boundary: NBITS=2, NSAMPLE=1, CMPO 0,1
        start2 = 1'b1;
        tick();                                     // cycle t+1
        start2 = 1'b0;
        check("n2_samp", 32'(sample2), 32'd1);
        tick();                                     // cycle t+2, CONV
        check("n2_samp_off", 32'(sample2), 32'd0);
        cmpo2 = 1'b0;
        tick();                                     // cycle t+3
        check("n2_novalid", 32'(valid2), 32'd0);
        cmpo2 = 1'b1;
        tick();                                     // cycle t+4
        check("n2_valid", 32'(valid2), 32'd1);
        check("n2_data",  32'(data2),  32'd1);
        check("n2_resn",  32'(resn2),  32'd2);
        tick();
        check("n2_idle",  32'(busy2),  32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
